mod_exp_ctrl: RTL

Sequences one shared Montgomery multiplier core to compute a modular exponentiation, left-to-right square-and-multiply, entirely in the Montgomery domain, followed by a final multiply by 1 to leave the domain. Sits between the top-level register interface and the multiplier. Owns the multiplier's operand muxes, start pulse and per-operation reset.

---
 rtl/mod_exp_pkg.sv | 50 +++++
 rtl/mod_exp_ctrl_mm_seq.sv | 36 +++
 rtl/mod_exp_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mod_exp_pkg.sv
// Shared types for the modular-exponentiation controller.
// Optional build macro: LEADING_ZERO_SKIP_EN (adds the SCAN state).
package mod_exp_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SQ_RST,
    SQ_GO,
    SQ_WAIT,
    MUL_RST,
    MUL_GO,
    MUL_WAIT,
    EXIT_RST,
    EXIT_GO,
    EXIT_WAIT,
`ifdef LEADING_ZERO_SKIP_EN
    SCAN,
`endif
    DONE
  } state_t;

  typedef enum logic [1:0] {
    SEL_ACC,
    SEL_X,
    SEL_ONE
  } sel_t;

  localparam logic [1:0] PH_NONE = 2'd0;
  localparam logic [1:0] PH_RST  = 2'd1;
  localparam logic [1:0] PH_GO   = 2'd2;
  localparam logic [1:0] PH_WAIT = 2'd3;

  function automatic logic [1:0] phase_of(input state_t s);
    case (s)
      SQ_RST, MUL_RST, EXIT_RST:    phase_of = PH_RST;
      SQ_GO, MUL_GO, EXIT_GO:       phase_of = PH_GO;
      SQ_WAIT, MUL_WAIT, EXIT_WAIT: phase_of = PH_WAIT;
      default:                      phase_of = PH_NONE;
    endcase
  endfunction

  function automatic sel_t sel_b_of(input state_t s);
    case (s)
      MUL_RST, MUL_GO, MUL_WAIT:    sel_b_of = SEL_X;
      EXIT_RST, EXIT_GO, EXIT_WAIT: sel_b_of = SEL_ONE;
      default:                      sel_b_of = SEL_ACC;
    endcase
  endfunction

endpackage

// File: rtl/mod_exp_ctrl_mm_seq.sv
// Multiplier phasing: registers the core reset/start strobes from the next
// phase and qualifies the core's done level with the WAIT phase only.
module mm_seq
  import mod_exp_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] phase_d,
  input  logic       mm_done,
  output logic       mm_resetn,
  output logic       mm_start,
  output logic       op_done
);

  logic [1:0] phase_q;
  logic       mm_resetn_q;
  logic       mm_start_q;

  // Phase register; the core is held in reset whenever no multiply is in GO/WAIT.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      phase_q     <= PH_NONE;
      mm_resetn_q <= 1'b0;
      mm_start_q  <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      mm_resetn_q <= (phase_d == PH_GO) || (phase_d == PH_WAIT);
      mm_start_q  <= (phase_d == PH_GO);
    end
  end

  assign mm_resetn = mm_resetn_q;
  assign mm_start  = mm_start_q;
  assign op_done   = (phase_q == PH_WAIT) && mm_done;

endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer around one Montgomery core.
// Optional build macro: LEADING_ZERO_SKIP_EN (skip leading zero exponent bits).
module mod_exp_ctrl
  import mod_exp_pkg::*;
#(
  parameter int WIDTH   = 1024,
  parameter int E_WIDTH = 1024
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_rmodm,
  input  logic [E_WIDTH-1:0] in_e,
  input  logic [WIDTH-1:0]   in_m,
  output logic [WIDTH-1:0]   result,
  output logic               done,
  output logic               busy,
  output logic               mm_resetn,
  output logic               mm_start,
  output logic [WIDTH-1:0]   mm_a,
  output logic [WIDTH-1:0]   mm_b,
  output logic [WIDTH-1:0]   mm_m,
  input  logic [WIDTH-1:0]   mm_result,
  input  logic               mm_done
);

  localparam int IW = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;
  localparam logic [IW-1:0] I_TOP = IW'(E_WIDTH - 1);
  localparam logic [WIDTH-1:0] MONT_ONE_LIT = {{(WIDTH-1){1'b0}}, 1'b1};
`ifdef LEADING_ZERO_SKIP_EN
  localparam state_t FIRST_ST = SCAN;
`else
  localparam state_t FIRST_ST = SQ_RST;
`endif

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d, x_q, x_d, m_q, m_d;
  logic [E_WIDTH-1:0] e_q, e_d;
  logic [IW-1:0]      i_q, i_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               done_q, busy_q;
  logic [WIDTH-1:0]   mm_a_q, mm_b_q, mm_m_q, mm_b_d;
  logic               op_done;

  mm_seq u_seq (
    .clk       (clk),
    .resetn    (resetn),
    .phase_d   (phase_of(state_d)),
    .mm_done   (mm_done),
    .mm_resetn (mm_resetn),
    .mm_start  (mm_start),
    .op_done   (op_done)
  );

  // Next-state, operand latching and bit-index advance.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    x_d      = x_q;
    e_d      = e_q;
    m_d      = m_q;
    i_d      = i_q;
    result_d = result_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          x_d     = in_x;
          e_d     = in_e;
          m_d     = in_m;
          acc_d   = in_rmodm;
          i_d     = I_TOP;
          state_d = FIRST_ST;
        end else begin
          state_d = state_q;
        end
      end
`ifdef LEADING_ZERO_SKIP_EN
      SCAN: begin
        if (e_q[i_q]) begin
          state_d = SQ_RST;
        end else if (i_q == IW'(0)) begin
          state_d = EXIT_RST;
        end else begin
          i_d = i_q - IW'(1);
        end
      end
`endif
      SQ_RST:   state_d = SQ_GO;
      SQ_GO:    state_d = SQ_WAIT;
      MUL_RST:  state_d = MUL_GO;
      MUL_GO:   state_d = MUL_WAIT;
      EXIT_RST: state_d = EXIT_GO;
      EXIT_GO:  state_d = EXIT_WAIT;
      SQ_WAIT, MUL_WAIT: begin
        if (op_done) begin
          acc_d = mm_result;
          if ((state_q == SQ_WAIT) && e_q[i_q]) begin
            state_d = MUL_RST;
          end else if (i_q == IW'(0)) begin
            state_d = EXIT_RST;
          end else begin
            i_d     = i_q - IW'(1);
            state_d = SQ_RST;
          end
        end else begin
          state_d = state_q;
        end
      end
      EXIT_WAIT: begin
        if (op_done) begin
          result_d = mm_result;
          state_d  = DONE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand B select for the multiply the FSM is entering.
  always_comb begin
    case (sel_b_of(state_d))
      SEL_X:   mm_b_d = x_d;
      SEL_ONE: mm_b_d = MONT_ONE_LIT;
      default: mm_b_d = acc_d;
    endcase
  end

  // State and datapath registers; operands are registered from next-state values
  // so they are already valid in the RST cycle and frozen until the core finishes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      x_q      <= '0;
      e_q      <= '0;
      m_q      <= '0;
      i_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      mm_a_q   <= '0;
      mm_b_q   <= '0;
      mm_m_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      x_q      <= x_d;
      e_q      <= e_d;
      m_q      <= m_d;
      i_q      <= i_d;
      result_q <= result_d;
      done_q   <= (state_d == DONE);
      busy_q   <= (state_d != IDLE) && (state_d != DONE);
      mm_a_q   <= acc_d;
      mm_b_q   <= mm_b_d;
      mm_m_q   <= m_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign mm_a   = mm_a_q;
  assign mm_b   = mm_b_q;
  assign mm_m   = mm_m_q;

endmodule
